// File: rtl/scr1_tcm_arbiter_pkg.sv
// Shared memory-interface types and TCM arbiter defaults.
// Imported by the arbiter top and its lane controller.
package scr1_tcm_arbiter_pkg;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'd0,
      SCR1_MEM_RESP_RDY_OK = 2'd1,
      SCR1_MEM_RESP_RDY_ER = 2'd2
   } type_scr1_mem_resp_e;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'd0,
      SCR1_MEM_WIDTH_HWORD = 2'd1,
      SCR1_MEM_WIDTH_WORD  = 2'd2
   } type_scr1_mem_width_e;

   localparam int unsigned SCR1_TCM_STARVE_LIMIT_DEF = 3;

endpackage

// File: rtl/scr1_tcm_lane_ctrl.sv
// Byte-lane logic for one data port: byte enables, write replication,
// misalignment detection and read-data shift/mask.
module scr1_tcm_lane_ctrl
   import scr1_tcm_arbiter_pkg::*;
(
   input  type_scr1_mem_width_e req_width,
   input  logic [1:0]           req_offs,
   input  logic [31:0]          req_wdata,
   output logic [3:0]           req_be,
   output logic [31:0]          req_wdata_rep,
   output logic                 req_misalign,
   input  type_scr1_mem_width_e rsp_width,
   input  logic [1:0]           rsp_offs,
   input  logic [31:0]          rsp_rdata_raw,
   output logic [31:0]          rsp_rdata
);

   logic [31:0] shifted;

   always_comb begin
      req_be        = 4'b1111;
      req_wdata_rep = req_wdata;
      req_misalign  = 1'b0;
      unique case (req_width)
         SCR1_MEM_WIDTH_BYTE: begin
            req_be        = 4'b0001 << req_offs;
            req_wdata_rep = {4{req_wdata[7:0]}};
         end
         SCR1_MEM_WIDTH_HWORD: begin
            req_be        = 4'b0011 << {req_offs[1], 1'b0};
            req_wdata_rep = {2{req_wdata[15:0]}};
            req_misalign  = req_offs[0];
         end
         default: begin
            req_misalign  = |req_offs;
         end
      endcase
   end

   assign shifted = rsp_rdata_raw >> {rsp_offs, 3'b000};

   always_comb begin
      rsp_rdata = shifted;
      unique case (rsp_width)
         SCR1_MEM_WIDTH_BYTE:  rsp_rdata = {24'h0, shifted[7:0]};
         SCR1_MEM_WIDTH_HWORD: rsp_rdata = {16'h0, shifted[15:0]};
         default:              rsp_rdata = shifted;
      endcase
   end

endmodule

// File: rtl/scr1_tcm_arbiter.sv
// Single-port TCM arbiter: shares one SRAM between imem and dmem,
// dmem first, with a bounded wait for imem.
module scr1_tcm_arbiter
   import scr1_tcm_arbiter_pkg::*;
#(
   parameter logic [31:0] SCR1_TCM_SIZE     = 32'h00010000,
   parameter int unsigned SCR1_STARVE_LIMIT = SCR1_TCM_STARVE_LIMIT_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              imem_req,
   output logic                              imem_req_ack,
   input  logic [31:0]                       imem_addr,
   output logic [31:0]                       imem_rdata,
   output type_scr1_mem_resp_e               imem_resp,
   input  logic                              dmem_req,
   output logic                              dmem_req_ack,
   input  type_scr1_mem_cmd_e                dmem_cmd,
   input  type_scr1_mem_width_e              dmem_width,
   input  logic [31:0]                       dmem_addr,
   input  logic [31:0]                       dmem_wdata,
   output logic [31:0]                       dmem_rdata,
   output type_scr1_mem_resp_e               dmem_resp,
   output logic                              mem_req,
   output logic                              mem_we,
   output logic [3:0]                        mem_be,
   output logic [$clog2(SCR1_TCM_SIZE)-3:0]  mem_addr,
   output logic [31:0]                       mem_wdata,
   input  logic [31:0]                       mem_rdata
);

   localparam int unsigned AW    = $clog2(SCR1_TCM_SIZE);
   localparam logic [3:0]  LIMIT = 4'(SCR1_STARVE_LIMIT);

   logic [3:0]           starve_cnt;
   logic                 i_gnt;
   logic                 d_gnt;
   logic                 i_err;
   logic                 d_err;
   logic [3:0]           d_be;
   logic [31:0]          d_wdata;
   logic                 d_misalign;
   logic [31:0]          d_rdata_al;
   logic [1:0]           d_offs_q;
   type_scr1_mem_width_e d_width_q;
   logic                 d_wr_q;
   type_scr1_mem_resp_e  i_resp_q;
   type_scr1_mem_resp_e  d_resp_q;

   scr1_tcm_lane_ctrl i_lane (
      .req_width     (dmem_width),
      .req_offs      (dmem_addr[1:0]),
      .req_wdata     (dmem_wdata),
      .req_be        (d_be),
      .req_wdata_rep (d_wdata),
      .req_misalign  (d_misalign),
      .rsp_width     (d_width_q),
      .rsp_offs      (d_offs_q),
      .rsp_rdata_raw (mem_rdata),
      .rsp_rdata     (d_rdata_al)
   );

   // imem overrides dmem only once its wait reaches the limit
   assign d_gnt = ~rst & dmem_req
                & ~(imem_req & (starve_cnt == LIMIT));
   assign i_gnt = ~rst & imem_req & ~d_gnt;

   assign imem_req_ack = i_gnt;
   assign dmem_req_ack = d_gnt;

   assign i_err = (imem_addr >= SCR1_TCM_SIZE) | (|imem_addr[1:0]);
   assign d_err = (dmem_addr >= SCR1_TCM_SIZE) | d_misalign;

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      if (d_gnt && !d_err) begin
         mem_req   = 1'b1;
         mem_we    = (dmem_cmd == SCR1_MEM_CMD_WR);
         mem_be    = d_be;
         mem_addr  = dmem_addr[AW-1:2];
         mem_wdata = d_wdata;
      end else if (i_gnt && !i_err) begin
         mem_req   = 1'b1;
         mem_be    = 4'b1111;
         mem_addr  = imem_addr[AW-1:2];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= 4'd0;
         i_resp_q   <= SCR1_MEM_RESP_NOTRDY;
         d_resp_q   <= SCR1_MEM_RESP_NOTRDY;
         d_offs_q   <= 2'b00;
         d_width_q  <= SCR1_MEM_WIDTH_WORD;
         d_wr_q     <= 1'b0;
      end else begin
         if (!imem_req || i_gnt)
            starve_cnt <= 4'd0;
         else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;

         if (!i_gnt)
            i_resp_q <= SCR1_MEM_RESP_NOTRDY;
         else if (i_err)
            i_resp_q <= SCR1_MEM_RESP_RDY_ER;
         else
            i_resp_q <= SCR1_MEM_RESP_RDY_OK;

         if (!d_gnt)
            d_resp_q <= SCR1_MEM_RESP_NOTRDY;
         else if (d_err)
            d_resp_q <= SCR1_MEM_RESP_RDY_ER;
         else
            d_resp_q <= SCR1_MEM_RESP_RDY_OK;

         if (d_gnt) begin
            d_offs_q  <= dmem_addr[1:0];
            d_width_q <= dmem_width;
            d_wr_q    <= (dmem_cmd == SCR1_MEM_CMD_WR);
         end
      end
   end

   assign imem_resp  = i_resp_q;
   assign dmem_resp  = d_resp_q;
   assign imem_rdata = (i_resp_q == SCR1_MEM_RESP_RDY_OK) ? mem_rdata : 32'h0;
   assign dmem_rdata = (d_resp_q == SCR1_MEM_RESP_RDY_OK && !d_wr_q)
                     ? d_rdata_al : 32'h0;

endmodule

// File: doc/scr1_tcm_arbiter.md
# scr1_tcm_arbiter

Single-port TCM arbiter: shares one single-port 32-bit SRAM macro between the core instruction (imem) and data (dmem) interfaces. It sits between the core memory router and a single-port `scr1_sp_memory` instance, and replaces the dual-port TCM where area matters. Each cycle it grants at most one requester, with dmem priority and a bounded-starvation guarantee for imem. It also generates byte enables and aligned read data, and flags out-of-range and misaligned accesses.

## Interface
- `SCR1_TCM_SIZE`, default 32'h00010000: TCM size in bytes; power of two, at least 8.
- `SCR1_STARVE_LIMIT`, default 3: consecutive imem denials after which imem wins; range 1..15.
- Port `clk`, input, 1: the single clock; all logic is on the rising edge.
- Port `rst`, input, 1: reset, synchronous and active-high.
- Port `imem_req`, input, 1: instruction fetch request.
- Port `imem_req_ack`, output, 1: imem request accepted this cycle (combinational).
- Port `imem_addr`, input, 32: fetch byte address.
- Port `imem_rdata`, output, 32: fetch data.
- Port `imem_resp`, output, `type_scr1_mem_resp_e`: fetch response.
- Port `dmem_req`, input, 1: data request.
- Port `dmem_req_ack`, output, 1: dmem request accepted this cycle (combinational).
- Port `dmem_cmd`, input, `type_scr1_mem_cmd_e`: read or write.
- Port `dmem_width`, input, `type_scr1_mem_width_e`: byte, halfword or word.
- Port `dmem_addr`, input, 32: data byte address.
- Port `dmem_wdata`, input, 32: write data, right-justified.
- Port `dmem_rdata`, output, 32: read data, right-justified.
- Port `dmem_resp`, output, `type_scr1_mem_resp_e`: data response.
- Port `mem_req`, output, 1: SRAM access strobe.
- Port `mem_we`, output, 1: SRAM write strobe (1 = write).
- Port `mem_be`, output, 4: SRAM byte enables.
- Port `mem_addr`, output, `$clog2(SCR1_TCM_SIZE)-2`: SRAM word address.
- Port `mem_wdata`, output, 32: SRAM write data.
- Port `mem_rdata`, input, 32: SRAM read data, valid the cycle after a read strobe.

## Operation
- **Grant rule**
  - Only dmem requesting: dmem wins.
  - Only imem requesting: imem wins.
  - Both requesting: dmem wins, unless `starve_cnt == SCR1_STARVE_LIMIT`; then imem wins.
- **`starve_cnt`** (4-bit)
  - Increments, saturating at `SCR1_STARVE_LIMIT`, each cycle imem requests and is not granted.
  - Clears when imem is granted or `imem_req` is 0.
- **Acknowledge**: `*_req_ack` is asserted only for the granted side. The loser must hold its request; its inputs are sampled again next cycle.
- **Error checks on an accepted request**
  - Address at or above `SCR1_TCM_SIZE` is an error.
  - dmem halfword with `addr[0]` set is an error.
  - dmem word with `addr[1:0]` nonzero is an error.
  - imem `addr[1:0]` nonzero is an error.
  - An erroring request is still acked, `mem_req` stays 0, and the response is `SCR1_MEM_RESP_RDY_ER`.
- **Valid access**
  - `mem_req` = 1 and `mem_addr` = `addr[$clog2(SIZE)-1:2]`.
  - For writes, `mem_we` = 1.
- **Byte lanes**
  - Byte: `mem_be` = `4'b0001 << addr[1:0]`, `mem_wdata` = `wdata[7:0]` replicated ×4.
  - Halfword: `mem_be` = `4'b0011 << {addr[1],1'b0}`, `mem_wdata` = `wdata[15:0]` replicated ×2.
  - Word: `mem_be` = 4'b1111, `mem_wdata` = `wdata`.
  - imem reads use `mem_be` = 4'b1111.
- **Read alignment**
  - `addr[1:0]` and `width` are registered at acceptance.
  - `dmem_rdata` = `mem_rdata >> 8*shift`, zero-extended to the access width: bytes masked to 8 bits, halfwords to 16.
- **Response data zeroing**
  - Write responses have `dmem_rdata` = 0.
  - Error responses have rdata = 0.
  - rdata is 0 whenever resp is NOTRDY.
- **Per-side response register**: NOTRDY, RDY_OK or RDY_ER, loaded every cycle from that cycle's grant outcome.

## Timing
- **Reset values**
  - `imem_resp` and `dmem_resp` = `SCR1_MEM_RESP_NOTRDY`.
  - `starve_cnt` = 0; `imem_rdata` and `dmem_rdata` = 0.
  - `mem_req`, `mem_we` and `mem_be` = 0, because no request is granted while `rst` = 1.
- **Latency**: an access accepted in cycle N gets its response (and rdata) in cycle N+1. Throughput is one access per cycle in total across both sides.
- **Acks during reset**: `*_req_ack` = 0 while `rst` = 1.
- **Reset mid-operation**: an access accepted in the cycle `rst` rises is dropped. Its response is NOTRDY in the next cycle. A write issued that cycle is also suppressed.
- **Back-to-back**: a requester may present a new request in the cycle its previous response appears.
- **Both requesting under the default limit**: with `SCR1_STARVE_LIMIT` = 3 and both sides requesting continuously, grants repeat D,D,D,I.
- **Simultaneous error and contention**: an erroring dmem request still consumes the grant slot.

## Structure
- Shared types come from `scr1_memif.svh`: `type_scr1_mem_resp_e`, `_cmd_e` and `_width_e`.
- Add `SCR1_TCM_STARVE_LIMIT_DEF` to the shared arch description header.
- Sub-module `scr1_tcm_lane_ctrl` is purely combinational. It owns byte-enable generation, write-data replication, misalignment detection, and read shift/mask.
  - It is instantiated once for dmem.
  - imem uses a fixed word path.
- The top module holds the arbitration logic, `starve_cnt`, and the response and alignment registers.

## Test plan
- **Idle after reset**: hold `rst` 3 cycles, then release with no requests. Both resps are NOTRDY, `mem_req` = 0, acks = 0.
- **Byte write then read**: dmem byte write 8'hA5 to 0x0006, then a word read of 0x0004. `mem_be` = 4'b0100; the read gives `dmem_rdata` = 32'h00A50000 with RDY_OK in cycle N+1.
- **Contention**: both sides request continuously for 8 cycles with limit 3. Grant sequence is D,D,D,I,D,D,D,I, and `imem_req_ack` pulses on cycles 4 and 8.
- **Errors**:
  - dmem halfword read at 0x0001 gives RDY_ER, rdata = 0, `mem_req` = 0.
  - imem fetch at `SCR1_TCM_SIZE` gives RDY_ER.
- **Reset mid-write**: assert `rst` in the cycle a dmem write is accepted. `mem_req` = 0, `dmem_resp` = NOTRDY next cycle, and a later read returns the old data.
- **Signed-halfword lane**: after a word write of 32'h8001_7FFE to 0x0010, a halfword read at 0x0012 gives 32'h00008001.
